// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen
// Turns a raw, bouncing push-button into clean single-cycle count-enable
// pulses for the downstream T-flip-flop counter, and reports the debounced
// button level for status LEDs.
//
// Optional build macro: ENABLE_PULSE_GEN_AUTO_REPEAT_EN
//   When defined, holding the button produces auto-repeat pulses: the first
//   one REPEAT_DELAY cycles after HELD entry, then one every REPEAT_RATE
//   cycles. When undefined, no repeat hardware exists and every accepted
//   press gives exactly one pulse.
//
// State table
//   state     | meaning
//   IDLE      | button released and stable, waiting for a synchronized 1
//   DEB_PRESS | button seen high, counting stable-high cycles
//   HELD      | press accepted (pulse issued), button still down
//   DEB_REL   | button seen low after HELD, counting stable-low cycles

module enable_pulse_gen #(
    parameter int DEB_CYCLES   = 20,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 25,
    parameter int CNT_W        = 24
) (
    input  logic Clk,
    input  logic Clr,
    input  logic Btn_in,
    output logic Enable,
    output logic Btn_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Reject parameter sets the timers or the pulse rules cannot honour.
    if (DEB_CYCLES < 2 || REPEAT_RATE < 2 || REPEAT_DELAY < 2 ||
        CNT_W < 1 || CNT_W > 31 ||
        DEB_CYCLES > (1 << CNT_W) || REPEAT_DELAY > (1 << CNT_W) ||
        REPEAT_RATE > (1 << CNT_W)) begin : g_param_check
        $error("enable_pulse_gen: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             enable_q, enable_d;
    logic             btn_state_q, btn_state_d;
    logic             press_pulse;
    logic             rpt_fire;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= Btn_in;
            s2_q <= s1_q;
        end
    end

    // FSM state, debounce timer and registered outputs.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            enable_q    <= 1'b0;
            btn_state_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            enable_q    <= enable_d;
            btn_state_q <= btn_state_d;
        end
    end

    // Next-state logic: debounce press and release around the HELD state.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_pulse = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = '0;
                end
            end
            DEB_REL: begin
                if (s2_q) begin
                    // Release bounce: back to HELD without a new pulse.
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        btn_state_d = (state_d == HELD) || (state_d == DEB_REL);
    end

`ifdef ENABLE_PULSE_GEN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic [CNT_W-1:0] rpt_last;

    // rpt_phase_q is 0 until the first repeat, then the period drops to REPEAT_RATE.
    assign rpt_last = rpt_phase_q ? RATE_LAST : DELAY_LAST;

    // Repeat timer register.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end

    // Repeat timer runs only while staying in HELD; any other edge clears it,
    // so every HELD entry restarts the full initial delay.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
        rpt_fire    = 1'b0;
        if (state_q == HELD && state_d == HELD) begin
            rpt_phase_d = rpt_phase_q;
            if (rpt_cnt_q == rpt_last) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Press and repeat pulses come from disjoint states, so OR is safe.
    assign enable_d  = press_pulse | rpt_fire;

    assign Enable    = enable_q;
    assign Btn_state = btn_state_q;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Self-checking bench for enable_pulse_gen. The reference model treats the
// design as "a level change is accepted after DEB_CYCLES+1 consecutive
// synchronized samples of the new level", plus an arithmetic repeat schedule
// when ENABLE_PULSE_GEN_AUTO_REPEAT_EN is defined.

module tb_enable_pulse_gen;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

`ifdef ENABLE_PULSE_GEN_AUTO_REPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Clr;
    logic Btn_in;
    logic Enable;
    logic Btn_state;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic m_p1, m_p2;     // button samples taken one and two edges ago
    logic m_level;        // accepted (debounced) level
    int   m_run;          // consecutive samples disagreeing with m_level
    int   m_hold;         // edges spent holding since HELD entry
    logic m_en;           // expected Enable after this edge
    logic [3:0] cnt4;     // downstream 4-bit counter fed by DUT Enable
    logic prev_en;

    enable_pulse_gen #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .CNT_W       (8)
    ) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .Btn_in   (Btn_in),
        .Enable   (Enable),
        .Btn_state(Btn_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic btn, input logic clr);
        logic smp;
        if (clr) begin
            m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0; m_hold = 0; m_en = 0;
        end else begin
            smp  = m_p2;
            m_en = 1'b0;
            if (smp != m_level) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = smp;
                    m_run   = 0;
                    if (smp) begin
                        m_en   = 1'b1;
                        m_hold = 0;
                    end
                end
            end else begin
                if (m_level && m_run > 0) begin
                    m_hold = 0;
                end else if (m_level) begin
                    m_hold++;
                    if (AUTO_RPT && m_hold >= RD && ((m_hold - RD) % RR) == 0)
                        m_en = 1'b1;
                end
                m_run = 0;
            end
            m_p2 = m_p1;
            m_p1 = btn;
        end
    endtask

    // One clock edge: drive, clock, sample 1 ns later, compare with the model.
    task automatic step(input logic btn, input logic clr);
        Btn_in = btn;
        Clr    = clr;
        @(posedge Clk);
        #1;
        model_edge(btn, clr);
        if (clr) cnt4 = 4'd0;
        else if (Enable === 1'b1) cnt4 = cnt4 + 4'd1;
        check("enable", {7'd0, Enable}, {7'd0, m_en});
        check("btn_state", {7'd0, Btn_state}, {7'd0, m_level});
        if (prev_en === 1'b1 && Enable === 1'b1)
            check("enable_back_to_back", {7'd0, Enable}, 8'd0);
        prev_en = Enable;
    endtask

    initial begin
        Btn_in = 0; Clr = 1; cnt4 = 0; prev_en = 0;
        m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0; m_hold = 0; m_en = 0;

        // 1: reset then clean press; pulse after edge 7, Btn_state from edge 7
        step(0, 1); step(0, 1);
        check("reset_enable", {7'd0, Enable}, 8'd0);
        check("reset_btn_state", {7'd0, Btn_state}, 8'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0);
            check("t1_enable_edge", {7'd0, Enable}, (i == 7) ? 8'd1 : 8'd0);
            check("t1_state_edge", {7'd0, Btn_state}, (i >= 7) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 12; i++) step(0, 0);
        check("t1_released", {7'd0, Btn_state}, 8'd0);

        // 2: bounce 1,1,0 x5 must be rejected
        step(0, 1);
        for (int r = 0; r < 5; r++) begin
            step(1, 0); step(1, 0); step(0, 0);
        end
        for (int i = 0; i < 8; i++) step(0, 0);
        check("t2_no_pulse", {4'd0, cnt4}, 8'd0);
        check("t2_btn_state", {7'd0, Btn_state}, 8'd0);

        // 3: held 20 cycles with 3 single-cycle glitches, then released
        step(0, 1);
        for (int i = 1; i <= 20; i++) step((i == 9 || i == 13 || i == 17) ? 1'b0 : 1'b1, 0);
        for (int i = 0; i < 12; i++) step(0, 0);
        check("t3_one_pulse", {4'd0, cnt4}, 8'd1);
        check("t3_released", {7'd0, Btn_state}, 8'd0);

        // 4: Clr for one edge at edge 12 while HELD; new pulse 7 edges later
        step(0, 1);
        for (int i = 1; i <= 11; i++) step(1, 0);
        step(1, 1);
        check("t4_clr_enable", {7'd0, Enable}, 8'd0);
        check("t4_clr_btn_state", {7'd0, Btn_state}, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1, 0);
            check("t4_repulse_edge", {7'd0, Enable}, (k == 7) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 12; i++) step(0, 0);

        // 5/6: held 30 cycles past HELD entry; 8 pulses with repeat, else 1
        step(0, 1);
        for (int i = 1; i <= 34; i++) step(1, 0);
        for (int i = 0; i < 12; i++) step(0, 0);
        check("t5_counter", {4'd0, cnt4}, AUTO_RPT ? 8'd8 : 8'd1);

        // randomized bouncing stimulus with occasional Clr
        step(0, 1);
        for (int seg = 0; seg < 120; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(10, 40))
                                                : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++)
                step(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
